keypad_scanner: RTL

- Upstream stage of the note-memory game module; drives a 4x4 matrix keypad and produces the debounced `keypad_input` code and `keypad_enable` level that the game module consumes.
- Scans columns one at a time, samples the synchronised rows and rejects multi-key (ghost) sweeps.
- Debounces press and release over whole sweeps, then presents a stable 4-bit key code with a held level and a one-cycle press pulse.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/kp_scan_timer.sv | 42 ++++
 rtl/keypad_scanner.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
//   kp_state_t   : debounce FSM state
//   KP_ROWS/COLS : matrix geometry
//   KP_CODE_NONE : key code presented while no key is held
//   kp_code()    : matrix index (row*4+col) to key code
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_PEND,
    HELD,
    RELEASE_PEND
  } kp_state_t;

  localparam int unsigned KP_ROWS      = 4;
  localparam int unsigned KP_COLS      = 4;
  localparam logic [3:0]  KP_CODE_NONE = 4'd0;

  // Code 0 means "no key", so indices shift up by one; index 15 would
  // overflow and shares code 15 with index 14.
  function automatic logic [3:0] kp_code(input logic [3:0] index);
    return (index == 4'd15) ? 4'd15 : index + 4'd1;
  endfunction

endpackage

// File: rtl/kp_scan_timer.sv
// Column scan timing for the keypad scanner.
//   clk, reset : system clock, asynchronous active-high reset
//   col_out_n  : one-hot active-low column drive, rotates left each step
//   col_idx    : index of the column currently driven
//   scan_tick  : one-clk pulse in the last cycle of each column step (sample point)
//   sweep_end  : scan_tick of column 3, i.e. the last sample of a sweep
module kp_scan_timer
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               reset,
  output logic [KP_COLS-1:0] col_out_n,
  output logic [1:0]         col_idx,
  output logic               scan_tick,
  output logic               sweep_end
);

  localparam int unsigned      DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      col_idx   <= '0;
      col_out_n <= {{(KP_COLS-1){1'b1}}, 1'b0};
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      col_idx   <= col_idx + 2'd1;
      col_out_n <= {col_out_n[KP_COLS-2:0], col_out_n[KP_COLS-1]};
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign scan_tick = (div_cnt == DIV_LAST);
  assign sweep_end = scan_tick && (col_idx == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with sweep-level debounce and ghost rejection.
//   clk, reset : system clock, asynchronous active-high reset
//   row_in_n   : keypad rows, active-low, asynchronous to clk
//   col_out_n  : one-hot active-low column drive
//   key_code   : code of the debounced held key, 0 when none
//   key_held   : high while a debounced key is held
//   key_press  : one-clk pulse when a press is accepted
//   scan_tick  : one-clk pulse at each column sample
// Optional: define KEYPAD_AUTOREPEAT_EN to re-pulse key_press every
// REPEAT_SCANS sweeps while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 50
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   row_in_n,
  output logic [3:0]   col_out_n,
  output logic [3:0]   key_code,
  output logic         key_held,
  output logic         key_press,
  output logic         scan_tick
);

  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
    $error("keypad_scanner: SCAN_DIV must be >= 2, DEBOUNCE_SCANS and REPEAT_SCANS >= 1");
  end

  localparam int unsigned      DCNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_SCANS - 1);

  logic [1:0] col_idx;
  logic       sweep_end;

  kp_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .col_out_n (col_out_n),
    .col_idx   (col_idx),
    .scan_tick (scan_tick),
    .sweep_end (sweep_end)
  );

  logic [KP_ROWS-1:0] row_s1, row_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_in_n;
      row_s2 <= row_s1;
    end
  end

  kp_state_t          state;
  logic [3:0]         cand;
  logic [DCNT_W-1:0]  dcnt;
  logic [1:0]         acc_cnt, nxt_cnt;
  logic [3:0]         acc_first, nxt_first;
  logic               acc_seen, nxt_seen;
  logic [KP_ROWS-1:0] row_hit;
  logic               sw_single;

  assign row_hit = ~row_s2;

  // Sweep totals including the column being sampled now, so the column-3
  // tick can evaluate the complete sweep while the accumulators clear.
  always_comb begin
    nxt_cnt   = acc_cnt;
    nxt_first = acc_first;
    nxt_seen  = acc_seen;
    for (int unsigned r = 0; r < KP_ROWS; r++) begin
      if (row_hit[r]) begin
        if (nxt_cnt == 2'd0) nxt_first = {r[1:0], col_idx};
        if (nxt_cnt != 2'd2) nxt_cnt = nxt_cnt + 2'd1;
      end
    end
    if (row_hit[cand[3:2]] && (col_idx == cand[1:0])) nxt_seen = 1'b1;
  end

  assign sw_single = (nxt_cnt == 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt   <= '0;
      acc_first <= '0;
      acc_seen  <= 1'b0;
    end else if (sweep_end) begin
      acc_cnt   <= '0;
      acc_first <= '0;
      acc_seen  <= 1'b0;
    end else if (scan_tick) begin
      acc_cnt   <= nxt_cnt;
      acc_first <= nxt_first;
      acc_seen  <= nxt_seen;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned      REP_W    = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
  logic [REP_W-1:0] rep_cnt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= '0;
      dcnt      <= '0;
      key_code  <= KP_CODE_NONE;
      key_held  <= 1'b0;
      key_press <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_press <= 1'b0;
      if (sweep_end) begin
        unique case (state)
          IDLE: begin
            if (sw_single) begin
              cand <= nxt_first;
              if (DEBOUNCE_SCANS == 1) begin
                state     <= HELD;
                dcnt      <= '0;
                key_code  <= kp_code(nxt_first);
                key_held  <= 1'b1;
                key_press <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt   <= '0;
`endif
              end else begin
                state <= PRESS_PEND;
                dcnt  <= DCNT_W'(1);
              end
            end
          end
          PRESS_PEND: begin
            if (sw_single && (nxt_first == cand)) begin
              if (dcnt == DCNT_LAST) begin
                state     <= HELD;
                dcnt      <= '0;
                key_code  <= kp_code(cand);
                key_held  <= 1'b1;
                key_press <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt   <= '0;
`endif
              end else begin
                dcnt <= dcnt + DCNT_W'(1);
              end
            end else if (sw_single) begin
              cand <= nxt_first;
              dcnt <= DCNT_W'(1);
            end else begin
              state <= IDLE;
              dcnt  <= '0;
            end
          end
          HELD: begin
            if (nxt_seen) begin
`ifdef KEYPAD_AUTOREPEAT_EN
              if (rep_cnt == REP_LAST) begin
                rep_cnt   <= '0;
                key_press <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
              end
`endif
            end else if (DEBOUNCE_SCANS == 1) begin
              state    <= IDLE;
              dcnt     <= '0;
              key_code <= KP_CODE_NONE;
              key_held <= 1'b0;
            end else begin
              state <= RELEASE_PEND;
              dcnt  <= DCNT_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt <= '0;
`endif
            end
          end
          RELEASE_PEND: begin
            if (nxt_seen) begin
              // Release glitch: resume holding without a new press pulse.
              state <= HELD;
              dcnt  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt <= '0;
`endif
            end else if (dcnt == DCNT_LAST) begin
              state    <= IDLE;
              dcnt     <= '0;
              key_code <= KP_CODE_NONE;
              key_held <= 1'b0;
            end else begin
              dcnt <= dcnt + DCNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule
